// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. One nibble at a time is presented to a shared hex decoder while the
// matching anode is pulled low; each digit slot is followed by an all-dark
// blanking gap to suppress ghosting. New display words arrive over a
// valid/ready handshake and are committed only at frame boundaries.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load_valid  new display word offered
//   load_ready  pending buffer empty (transfer on load_valid & load_ready)
//   value       four hex digits, digit0 = value[3:0]
//   dp_in       per-digit decimal point, active-high
//   en_mask     per-digit enable, 0 keeps the digit dark
//   digit       nibble to the shared decoder
//   dp          decimal point of the current digit, active-high
//   an          anode selects, active-low, at most one low
//   frame_done  one-cycle pulse in the cycle SHOW(0) of a new frame begins
module seg_scan_ctrl #(
  parameter int unsigned DIV          = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter bit          LZB          = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_mask,
  output logic [3:0]  digit,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX   = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 32'd1 : 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_t;

  // Which digits actually light: enabled, and (with LZB) not part of a run of
  // leading zeros. Digit0 is never suppressed by LZB.
  function automatic logic [3:0] lit_mask(input disp_t d, input logic lzb);
    logic [3:0] lit;
    lit[0] = d.en[0];
    lit[1] = d.en[1] & ~(lzb & (d.value[15:4]  == 12'h000));
    lit[2] = d.en[2] & ~(lzb & (d.value[15:8]  == 8'h00));
    lit[3] = d.en[3] & ~(lzb & (d.value[15:12] == 4'h0));
    return lit;
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  disp_t         active_q, active_d;
  disp_t         pending_q, pending_d;
  logic          pend_full_q, pend_full_d;
  logic          boundary_q, boundary_d;
  logic          load_ready_q, load_ready_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    digit_q, digit_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          xfer;
  logic          advance;
  disp_t         in_word;
  logic [3:0]    lit;

  assign xfer    = load_valid & ~pend_full_q;
  assign in_word = '{value: value, dp: dp_in, en: en_mask};
  assign lit     = lit_mask(active_q, LZB);

  // Scan sequencing, frame-boundary commit and load buffering.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    boundary_d  = 1'b0;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          // The first word bypasses pending and starts the scan at once.
          active_d = in_word;
          state_d  = ST_SHOW;
          idx_d    = 2'd0;
          cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (HAS_BLANK) begin
            state_d = ST_BLANK;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase

    if (advance) begin
      state_d = ST_SHOW;
      idx_d   = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        // Wrap to digit0: frame boundary, commit any pending word.
        boundary_d = 1'b1;
        if (pend_full_q) begin
          active_d    = pending_q;
          pend_full_d = 1'b0;
        end else begin
          active_d = active_q;
        end
      end else begin
        boundary_d = 1'b0;
      end
    end else begin
      boundary_d = 1'b0;
    end

    // A transfer while scanning parks in pending; it cannot collide with the
    // commit above because xfer requires pend_full_q to be clear.
    if (xfer && (state_q == ST_SHOW || state_q == ST_BLANK)) begin
      pending_d   = in_word;
      pend_full_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end

    load_ready_d = ~pend_full_d;
  end

  // Output stage: drives the display from the current slot, one cycle behind
  // the sequencer so every output comes straight from a flop.
  always_comb begin
    an_d         = 4'hF;
    dp_d         = 1'b0;
    digit_d      = digit_q;
    frame_done_d = boundary_q;
    if (state_q == ST_SHOW) begin
      digit_d = nibble_sel(active_q.value, idx_q);
      if (lit[idx_q]) begin
        an_d = ~(4'b0001 << idx_q);
        dp_d = active_q.dp[idx_q];
      end else begin
        an_d = 4'hF;
        dp_d = 1'b0;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      boundary_q   <= 1'b0;
      load_ready_q <= 1'b1;
      an_q         <= 4'hF;
      digit_q      <= 4'h0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      boundary_q   <= boundary_d;
      load_ready_q <= load_ready_d;
      an_q         <= an_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign an         = an_q;
  assign digit      = digit_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BL    = 2;
  localparam int SEG   = DIV + BL;
  localparam int FRAME = 4 * SEG;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  en_mask;
  logic        load_ready;
  logic [3:0]  digit;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.DIV(DIV), .BLANK_CYCLES(BL), .LZB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .value(value), .dp_in(dp_in), .en_mask(en_mask),
    .digit(digit), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fd = -1;

  // Behavioural model: frame position t runs 0..FRAME-1 once scanning.
  bit          running, fresh, pfull;
  int          t;
  logic [15:0] a_val, p_val;
  logic [3:0]  a_dp, a_en, p_dp, p_en;
  logic [3:0]  e_an, e_digit;
  logic        e_dp, e_fd, e_ready;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit lit_of(input int i);
    if (!a_en[i]) return 1'b0;
    if (i > 0 && (a_val >> (4 * i)) == 16'h0000) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    running = 0; fresh = 0; pfull = 0; t = 0;
    a_val = 16'h0; a_dp = 4'h0; a_en = 4'h0;
    p_val = 16'h0; p_dp = 4'h0; p_en = 4'h0;
    e_an = 4'hF; e_digit = 4'h0; e_dp = 1'b0; e_fd = 1'b0; e_ready = 1'b1;
    last_fd = -1;
  endtask

  task automatic model_step();
    bit xfer;
    int slot;
    xfer = load_valid && !pfull;
    // outputs reflect the slot occupied before this edge
    e_an = 4'hF; e_dp = 1'b0;
    e_fd = running && (t == 0) && !fresh;
    if (running && (t % SEG) < DIV) begin
      slot = t / SEG;
      e_digit = a_val[slot*4 +: 4];
      if (lit_of(slot)) begin
        e_an = ~(4'b0001 << slot);
        e_dp = a_dp[slot];
      end
    end
    if (!running) begin
      if (xfer) begin
        a_val = value; a_dp = dp_in; a_en = en_mask;
        running = 1; t = 0; fresh = 1;
      end
    end else begin
      if (t == FRAME - 1) begin
        t = 0; fresh = 0;
        if (pfull) begin
          a_val = p_val; a_dp = p_dp; a_en = p_en; pfull = 0;
        end
      end else begin
        t = t + 1;
      end
      if (xfer) begin
        p_val = value; p_dp = dp_in; p_en = en_mask; pfull = 1;
      end
    end
    e_ready = !pfull;
  endtask

  task automatic compare();
    if (!rst_n) begin
      check("rst_an", {12'h0, an}, 16'h000F);
      check("rst_digit", {12'h0, digit}, 16'h0000);
      check("rst_dp", {15'h0, dp}, 16'h0000);
      check("rst_fd", {15'h0, frame_done}, 16'h0000);
      check("rst_ready", {15'h0, load_ready}, 16'h0001);
    end else begin
      check("an", {12'h0, an}, {12'h0, e_an});
      check("digit", {12'h0, digit}, {12'h0, e_digit});
      check("dp", {15'h0, dp}, {15'h0, e_dp});
      check("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
      check("load_ready", {15'h0, load_ready}, {15'h0, e_ready});
      check("one_anode", 16'($countones(~an) <= 1), 16'h0001);
      check("dp_dark", {15'h0, dp && (an == 4'hF)}, 16'h0000);
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) check("fd_period", 16'(cyc - last_fd), 16'(FRAME));
        last_fd = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic drive(input logic lv, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    load_valid = lv; value = v; dp_in = d; en_mask = e;
  endtask

  task automatic load_commit(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    int n;
    drive(1'b1, v, d, e);
    tick();
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    n = 0;
    while (pfull && n < 2 * FRAME) begin tick(); n++; end
    check("commit_timeout", {15'h0, pfull}, 16'h0000);
  endtask

  logic [3:0] an_log [0:25];
  logic [3:0] dg_log [0:25];
  logic       fd_log [0:25];

  initial begin
    int n, c_a, c_b, c_dp;
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    tick();

    // IDLE load of 26BE; anode for digit0 goes low one edge after transfer
    drive(1'b1, 16'h26BE, 4'h0, 4'hF);
    tick();
    check("first_an_dark", {12'h0, an}, 16'h000F);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    for (int k = 1; k <= 25; k++) begin
      tick();
      an_log[k] = an; dg_log[k] = digit; fd_log[k] = frame_done;
    end
    check("k1_an", {12'h0, an_log[1]}, 16'h000E);
    check("k1_digit", {12'h0, dg_log[1]}, 16'h000E);
    check("k4_an", {12'h0, an_log[4]}, 16'h000E);
    check("k5_an", {12'h0, an_log[5]}, 16'h000F);
    check("k7_an", {12'h0, an_log[7]}, 16'h000D);
    check("k7_digit", {12'h0, dg_log[7]}, 16'h000B);
    check("k13_an", {12'h0, an_log[13]}, 16'h000B);
    check("k13_digit", {12'h0, dg_log[13]}, 16'h0006);
    check("k22_an", {12'h0, an_log[22]}, 16'h0007);
    check("k22_digit", {12'h0, dg_log[22]}, 16'h0002);
    check("k1_fd", {15'h0, fd_log[1]}, 16'h0000);
    check("k25_fd", {15'h0, fd_log[25]}, 16'h0001);

    // mid-frame load during digit1, then a second word held while pending full
    n = 0;
    while (!(t >= SEG && t < SEG + DIV) && n < 2 * FRAME) begin tick(); n++; end
    drive(1'b1, 16'h1234, 4'h0, 4'hF);
    tick();
    check("ready_low_mid", {15'h0, load_ready}, 16'h0000);
    drive(1'b1, 16'hABCD, 4'h0, 4'hF);
    n = 0;
    while (pfull && n < 2 * FRAME) begin tick(); n++; end
    check("ready_back", {15'h0, load_ready}, 16'h0001);
    tick();
    check("new_frame_an", {12'h0, an}, 16'h000E);
    check("new_frame_digit", {12'h0, digit}, 16'h0004);
    check("new_frame_fd", {15'h0, frame_done}, 16'h0001);
    check("second_taken", {15'h0, load_ready}, 16'h0000);
    drive(1'b0, 16'h0, 4'h0, 4'h0);

    // transfer in the boundary cycle with empty pending commits a frame later
    n = 0;
    while (!(t == FRAME - 1 && !pfull) && n < 3 * FRAME) begin tick(); n++; end
    drive(1'b1, 16'h0050, 4'h0, 4'hF);
    tick();
    check("ready_low_boundary", {15'h0, load_ready}, 16'h0000);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (FRAME) tick();
    c_a = 0; c_b = 0;
    repeat (FRAME) begin
      tick();
      check("lzb_hi_dark", {14'h0, an[3:2]}, 16'h0003);
      if (an == 4'hE) c_a++;
      if (an == 4'hD) c_b++;
    end
    check("lzb_d0_cycles", 16'(c_a), 16'(DIV));
    check("lzb_d1_cycles", 16'(c_b), 16'(DIV));

    // value 0: only digit0 lit
    load_commit(16'h0000, 4'h0, 4'hF);
    c_a = 0;
    repeat (FRAME) begin
      tick();
      check("zero_hi_dark", {13'h0, an[3:1]}, 16'h0007);
      if (an == 4'hE) c_a++;
    end
    check("zero_d0_cycles", 16'(c_a), 16'(DIV));

    // masked digits stay dark but keep their slots; dp only on a dark digit
    load_commit(16'h26BE, 4'b0010, 4'b0101);
    c_a = 0; c_b = 0; c_dp = 0;
    repeat (FRAME) begin
      tick();
      check("mask_dark", {14'h0, an[3], an[1]}, 16'h0003);
      if (an == 4'hE) c_a++;
      if (an == 4'hB) c_b++;
      if (dp) c_dp++;
    end
    check("mask_d0_cycles", 16'(c_a), 16'(DIV));
    check("mask_d2_cycles", 16'(c_b), 16'(DIV));
    check("mask_dp_count", 16'(c_dp), 16'h0000);

    // asynchronous reset in the middle of a SHOW slot
    n = 0;
    while (!(running && (t % SEG) == 1) && n < 2 * FRAME) begin tick(); n++; end
    #2 rst_n = 1'b0;
    #1;
    check("async_an", {12'h0, an}, 16'h000F);
    check("async_digit", {12'h0, digit}, 16'h0000);
    check("async_ready", {15'h0, load_ready}, 16'h0001);
    drive(1'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (30) tick();
    check("stays_dark", {12'h0, an}, 16'h000F);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
